// File: rtl/fn_check_pkg.sv
// Shared encodings and constants for the F-function response checker.
package fn_check_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Expected F per vector: bit i is F for {A,B,C,D} = i, F = (A xor B)(C + D')
    localparam logic [15:0] GOLDEN_DEFAULT = 16'h0DD0;

    // Width of the applied {A,B,C,D} vector
    localparam int VEC_W = 4;

endpackage

// File: rtl/fn_response_checker_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// clear loads SETTLE_CYC-1; enable counts down to zero; expired flags zero.
module settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on clear, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fn_response_checker.sv
// Self-check engine: sweeps {A,B,C,D} = 0..15 into the function block,
// samples the returned F after a settle time and scores it against GOLDEN.
// Every output is a flop; f_in only reaches them through the SAMPLE update.
module fn_response_checker
    import fn_check_pkg::*;
#(
    parameter logic [15:0] GOLDEN     = GOLDEN_DEFAULT,
    parameter int          SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic [VEC_W-1:0] vec_out,
    output logic             vec_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_seen
);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [4:0]       err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             fs_q, fs_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             vv_q, vv_d;
    logic             pass_q, pass_d;
    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_expired;

    settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    // Next-state, scoreboard update and registered-output values
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        err_d      = err_q;
        ff_d       = ff_q;
        fs_d       = fs_q;
        done_d     = done_q;
        busy_d     = busy_q;
        vv_d       = vv_q;
        pass_d     = pass_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                // done/pass are only ever set from the DONE state, so holding
                // them here keeps results until the next accepted start
                if (state_q == DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    vv_d   = 1'b0;
                    pass_d = (err_q == 5'd0);
                end
                if (start) begin
                    state_d   = APPLY;
                    vec_d     = '0;
                    err_d     = 5'd0;
                    ff_d      = '0;
                    fs_d      = 1'b0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    vv_d      = 1'b1;
                    tmr_clear = 1'b1;
                end
            end
            APPLY: begin
                tmr_enable = 1'b1;
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (f_in != GOLDEN[vec_q]) begin
                    err_d = err_q + 5'd1;
                    if (!fs_q) begin
                        ff_d = vec_q;
                        fs_d = 1'b1;
                    end
                end
                // Last vector ends the sweep rather than wrapping to 0
                if (vec_q == '1) begin
                    state_d = DONE;
                    vv_d    = 1'b0;
                end else begin
                    state_d   = APPLY;
                    vec_d     = vec_q + 1'b1;
                    tmr_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= 5'd0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            vv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            vv_q    <= vv_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out    = vec_q;
    assign vec_valid  = vv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign fail_seen  = fs_q;

endmodule

// File: tb/tb_fn_response_checker.sv
// Bench for fn_response_checker: two instances (SETTLE_CYC=2 and 1) driven by
// behavioural function models; expected sweep results go through a scoreboard.
module tb_fn_response_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] f_in;
    logic [3:0] vec_out [2];
    logic [1:0] vec_valid;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] pass;
    logic [4:0] err_cnt [2];
    logic [3:0] first_fail [2];
    logic [1:0] fail_seen;
    int         mode [2];

    typedef struct {
        int err;
        int ff;
        int fs;
        int pas;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Reference F = (A xor B)(C + D') written from the boolean expression
    function automatic logic f_ref(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return (a ^ b) & (c | ~d);
    endfunction

    // Function-block models: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted at 15
    function automatic logic f_model(input int m, input logic [3:0] v);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (v == 4'd15) ? ~f_ref(v) : f_ref(v);
            default: return f_ref(v);
        endcase
    endfunction

    assign f_in[0] = f_model(mode[0], vec_out[0]);
    assign f_in[1] = f_model(mode[1], vec_out[1]);

    fn_response_checker #(.SETTLE_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start[0]), .f_in(f_in[0]),
        .vec_out(vec_out[0]), .vec_valid(vec_valid[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
        .first_fail(first_fail[0]), .fail_seen(fail_seen[0])
    );

    fn_response_checker #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .f_in(f_in[1]),
        .vec_out(vec_out[1]), .vec_valid(vec_valid[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
        .first_fail(first_fail[1]), .fail_seen(fail_seen[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int sel, input string tag);
        chk({tag, "_vec"},   int'(vec_out[sel]), 0);
        chk({tag, "_vv"},    int'(vec_valid[sel]), 0);
        chk({tag, "_busy"},  int'(busy[sel]), 0);
        chk({tag, "_done"},  int'(done[sel]), 0);
        chk({tag, "_pass"},  int'(pass[sel]), 0);
        chk({tag, "_err"},   int'(err_cnt[sel]), 0);
        chk({tag, "_ff"},    int'(first_fail[sel]), 0);
        chk({tag, "_fs"},    int'(fail_seen[sel]), 0);
    endtask

    // One sweep on instance sel. repulse_vec>=0 pulses start while that vector
    // is applied; abort_vec>=0 asserts rst while that vector is applied.
    task automatic sweep(input int sel, input int repulse_vec, input int abort_vec);
        int   s;
        int   n;
        bit   pulsed;
        exp_t e;
        exp_t got;
        s      = (sel == 0) ? 2 : 1;
        pulsed = 1'b0;
        e.err  = 0;
        e.ff   = 0;
        e.fs   = 0;
        for (int v = 0; v < 16; v++) begin
            if (f_model(mode[sel], 4'(v)) != f_ref(4'(v))) begin
                if (e.fs == 0) e.ff = v;
                e.fs = 1;
                e.err++;
            end
        end
        e.pas = (e.err == 0) ? 1 : 0;
        e.cyc = 16 * (s + 1) + 1;
        if (abort_vec < 0) sb.push_back(e);

        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
        n = 0;
        chk("busy_after_start", int'(busy[sel]), 1);
        chk("done_cleared", int'(done[sel]), 0);
        if (sel == 1) chk("seq_vec", int'(vec_out[sel]), 0);

        while (done[sel] !== 1'b1 && n < 300) begin
            if (abort_vec >= 0 && int'(vec_out[sel]) == abort_vec) begin
                rst = 1'b1;
                #1;
                chk_all_zero(sel, "abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start[sel] = (repulse_vec >= 0 && !pulsed && int'(vec_out[sel]) == repulse_vec);
            if (start[sel]) pulsed = 1'b1;
            @(posedge clk);
            n++;
            #1;
            start[sel] = 1'b0;
            if (sel == 1 && n < 32) begin
                chk("seq_vec", int'(vec_out[sel]), n / 2);
                chk("seq_vv", int'(vec_valid[sel]), 1);
            end
        end

        if (done[sel] !== 1'b1) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        got.err = int'(err_cnt[sel]);
        got.ff  = int'(first_fail[sel]);
        got.fs  = int'(fail_seen[sel]);
        got.pas = int'(pass[sel]);
        got.cyc = n;
        e = sb.pop_front();
        chk("done_latency", got.cyc, e.cyc);
        chk("err_cnt", got.err, e.err);
        chk("fail_seen", got.fs, e.fs);
        if (e.fs != 0) chk("first_fail", got.ff, e.ff);
        chk("pass", got.pas, e.pas);
        chk("busy_at_done", int'(busy[sel]), 0);
        chk("vv_at_done", int'(vec_valid[sel]), 0);
        // Results must hold while idle in DONE
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", int'(done[sel]), 1);
        chk("err_held", int'(err_cnt[sel]), e.err);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 2'b00;
        mode[0] = 0;
        mode[1] = 0;
        repeat (3) @(negedge clk);
        chk_all_zero(0, "reset2");
        chk_all_zero(1, "reset1");
        rst = 1'b0;

        mode[0] = 0; sweep(0, -1, -1);
        mode[0] = 1; sweep(0, -1, -1);
        mode[0] = 2; sweep(0, -1, -1);
        mode[0] = 3; sweep(0, -1, -1);
        mode[0] = 0; sweep(0, 5, -1);
        mode[0] = 0; sweep(0, -1, 7);
        mode[0] = 0; sweep(0, -1, -1);
        mode[1] = 0; sweep(1, -1, -1);
        mode[1] = 1; sweep(1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
